tl_cfg_shadow: RTL and testbench

- Parametrised successor to our single-field PCIe hard-IP config sampler: captures any selectable subset of the 16 time-multiplexed tl_cfg_ctl addresses into a shadow register file.
- Adds per-address valid bits, a readback port, change-event reporting and a stale-bus watchdog.
- Sits between the PCIe hard IP tl_cfg_* outputs and the fejkon_pcie_data TLP logic, which consumes my_id and reads other shadowed fields, e.g. device control and MSI.

---
 rtl/tl_cfg_shadow.sv | 130 +++++++++++++
 tb/tb_tl_cfg_shadow.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_cfg_shadow.sv
// tl_cfg_shadow
//   Samples the time-multiplexed PCIe hard-IP tl_cfg_ctl bus into a 16-entry
//   shadow register file. Only addresses selected by ADDR_MASK are captured.
//   Each capture is timed from the toggle of tl_cfg_add[0], delayed so that
//   the sample lands inside the hold window.
//
// Ports
//   clk             core clock, same domain as the tl_cfg_* outputs
//   reset_n         asynchronous active-low reset
//   tl_cfg_add      hard-IP config address; bit 0 toggles on every advance
//   tl_cfg_ctl      hard-IP config data for tl_cfg_add
//   rd_addr         shadow readback address
//   rd_data         shadow[rd_addr], registered
//   rd_valid        valid[rd_addr], registered alongside rd_data
//   my_id           {bus, dev, 3'h0} taken from shadow[15][12:0]
//   my_id_valid     valid[15]
//   cfg_change      one-cycle pulse when a shadowed entry gets a new value
//   cfg_change_addr address of the last change, held between pulses
//   stale           no capture strobe for TIMEOUT_CYCLES cycles
module tl_cfg_shadow #(
  parameter int unsigned SAMPLE_DELAY   = 2,
  parameter logic [15:0] ADDR_MASK      = 16'h8000,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  tl_cfg_add,
  input  logic [31:0] tl_cfg_ctl,
  input  logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic [15:0] my_id,
  output logic        my_id_valid,
  output logic        cfg_change,
  output logic [3:0]  cfg_change_addr,
  output logic        stale
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  primed_q, primed_d;
  logic [SAMPLE_DELAY:0] pipe_q, pipe_d;
  logic                  strobe;

  logic [31:0]           shadow_q [16];
  logic [31:0]           shadow_d [16];
  logic [15:0]           valid_q, valid_d;

  logic [31:0]           rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  cfg_change_q, cfg_change_d;
  logic [3:0]            cfg_change_addr_q, cfg_change_addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  // pipe_q[0] is the registered toggle; the last stage is the capture strobe.
  assign strobe = pipe_q[SAMPLE_DELAY];

  always_comb begin
    // The first edge after reset loads both sync stages with the live bus
    // level, so a held odd address is not mistaken for a fresh toggle.
    sync1_d  = tl_cfg_add[0];
    sync2_d  = primed_q ? sync1_q : tl_cfg_add[0];
    primed_d = 1'b1;

    // Shift in the new toggle; the width cast also covers SAMPLE_DELAY = 0.
    pipe_d = (SAMPLE_DELAY + 1)'({pipe_q, (sync1_q != sync2_q)});

    shadow_d          = shadow_q;
    valid_d           = valid_q;
    cfg_change_d      = 1'b0;
    cfg_change_addr_d = cfg_change_addr_q;
    cnt_d             = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    if (strobe) begin
      cnt_d = '0;
      if (ADDR_MASK[tl_cfg_add]) begin
        shadow_d[tl_cfg_add] = tl_cfg_ctl;
        valid_d[tl_cfg_add]  = 1'b1;
        if (!valid_q[tl_cfg_add] || (shadow_q[tl_cfg_add] != tl_cfg_ctl)) begin
          cfg_change_d      = 1'b1;
          cfg_change_addr_d = tl_cfg_add;
        end
      end
    end

    // Reads use the pre-write state, so a colliding write shows a cycle later.
    rd_data_d  = shadow_q[rd_addr];
    rd_valid_d = valid_q[rd_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q           <= 1'b0;
      sync2_q           <= 1'b0;
      primed_q          <= 1'b0;
      pipe_q            <= '0;
      shadow_q          <= '{default: '0};
      valid_q           <= '0;
      rd_data_q         <= '0;
      rd_valid_q        <= 1'b0;
      cfg_change_q      <= 1'b0;
      cfg_change_addr_q <= '0;
      cnt_q             <= '0;
    end else begin
      sync1_q           <= sync1_d;
      sync2_q           <= sync2_d;
      primed_q          <= primed_d;
      pipe_q            <= pipe_d;
      shadow_q          <= shadow_d;
      valid_q           <= valid_d;
      rd_data_q         <= rd_data_d;
      rd_valid_q        <= rd_valid_d;
      cfg_change_q      <= cfg_change_d;
      cfg_change_addr_q <= cfg_change_addr_d;
      cnt_q             <= cnt_d;
    end
  end

  assign rd_data         = rd_data_q;
  assign rd_valid        = rd_valid_q;
  assign my_id           = {shadow_q[15][12:0], 3'b000};
  assign my_id_valid     = valid_q[15];
  assign cfg_change      = cfg_change_q;
  assign cfg_change_addr = cfg_change_addr_q;
  assign stale           = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_tl_cfg_shadow.sv
// tb_tl_cfg_shadow
//   Scoreboard bench for tl_cfg_shadow. Stimulus predicts each capture
//   (cycle, address, data, expected change pulse) from a plain array model
//   and queues it. The monitor owns a second array model of the committed
//   shadow contents and checks every output on each falling edge.
module tb_tl_cfg_shadow;

  localparam int unsigned SD   = 2;
  localparam logic [15:0] MASK = 16'h8003;
  localparam int unsigned TO   = 64;

  logic        clk;
  logic        reset_n;
  logic [3:0]  tl_cfg_add;
  logic [31:0] tl_cfg_ctl;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [15:0] my_id;
  logic        my_id_valid;
  logic        cfg_change;
  logic [3:0]  cfg_change_addr;
  logic        stale;

  tl_cfg_shadow #(
    .SAMPLE_DELAY  (SD),
    .ADDR_MASK     (MASK),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .tl_cfg_add     (tl_cfg_add),
    .tl_cfg_ctl     (tl_cfg_ctl),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .my_id          (my_id),
    .my_id_valid    (my_id_valid),
    .cfg_change     (cfg_change),
    .cfg_change_addr(cfg_change_addr),
    .stale          (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [3:0]  addr;
    logic [31:0] data;
    bit          shadowed;
    bit          pulse;
  } rec_t;

  rec_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_pulses = 0;
  logic [31:0] sm_shadow [16];
  bit          sm_valid  [16];
  logic [31:0] mm_shadow [16];
  bit          mm_valid  [16];
  int          last_strobe = 0;
  logic [3:0]  last_rd = '0;
  bit          rd_rand = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  // Capture rule from the stimulus side: masked addresses are written, and
  // a pulse is due for a first write or a changed value.
  function automatic rec_t predict(input int c, input logic [3:0] a, input logic [31:0] d);
    rec_t r;
    r.cyc      = c;
    r.addr     = a;
    r.data     = d;
    r.shadowed = MASK[a];
    r.pulse    = MASK[a] && (!sm_valid[a] || sm_shadow[a] != d);
    if (MASK[a]) begin
      sm_shadow[a] = d;
      sm_valid[a]  = 1'b1;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      check("rd_data", rd_data, mm_shadow[last_rd]);
      check("rd_valid", {31'b0, rd_valid}, {31'b0, mm_valid[last_rd]});
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        void'(exp_q.pop_front());
        fail_now("strobe_missed");
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        rec_t r;
        r = exp_q.pop_front();
        check("cfg_change", {31'b0, cfg_change}, {31'b0, r.pulse});
        if (r.pulse) check("cfg_change_addr", {28'b0, cfg_change_addr}, {28'b0, r.addr});
        if (r.shadowed) begin
          mm_shadow[r.addr] = r.data;
          mm_valid[r.addr]  = 1'b1;
        end
        last_strobe = cyc;
      end else if (cfg_change) begin
        fail_now("cfg_change_unexpected");
      end
      if (cfg_change) n_pulses++;
      check("my_id", {16'b0, my_id}, {16'b0, mm_shadow[15][12:0], 3'b000});
      check("my_id_valid", {31'b0, my_id_valid}, {31'b0, mm_valid[15]});
      check("stale", {31'b0, stale}, {31'b0, ((cyc - last_strobe) >= int'(TO))});
    end
    last_rd = rd_addr;
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (rd_rand) rd_addr = 4'($urandom);
  endtask

  // Called at posedge+2: the next edge is the first to see the new value.
  task automatic issue(input logic [3:0] a, input logic [31:0] d, input int hold);
    bit tog;
    tog        = (a[0] != tl_cfg_add[0]);
    tl_cfg_add = a;
    tl_cfg_ctl = d;
    if (tog) exp_q.push_back(predict(cyc + 1 + 2 + int'(SD), a, d));
    repeat (hold) tick();
  endtask

  // Toggles every cycle; each capture samples the bus as it stands then.
  task automatic burst(input int n);
    logic [3:0]  ba [32];
    logic [31:0] bd [32];
    logic        b0;
    int          e0;
    int          j;
    b0 = tl_cfg_add[0];
    for (int i = 0; i < n; i++) begin
      ba[i]    = 4'($urandom);
      b0       = ~b0;
      ba[i][0] = b0;
      if ($urandom_range(0, 1) == 1) ba[i][3:1] = b0 ? 3'b111 : 3'b000;
      bd[i]    = 32'h100 * $urandom_range(0, 2);
    end
    e0 = cyc + 1;
    for (int i = 0; i < n; i++) begin
      j = i + 2 + int'(SD);
      if (j > n - 1) j = n - 1;
      exp_q.push_back(predict(e0 + i + 2 + int'(SD), ba[j], bd[j]));
    end
    for (int i = 0; i < n; i++) begin
      tl_cfg_add = ba[i];
      tl_cfg_ctl = bd[i];
      tick();
    end
    repeat (8) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
    check("rst_my_id", {16'b0, my_id}, 32'h0);
    check("rst_my_id_valid", {31'b0, my_id_valid}, 32'h0);
    check("rst_cfg_change", {31'b0, cfg_change}, 32'h0);
    check("rst_cfg_change_addr", {28'b0, cfg_change_addr}, 32'h0);
    check("rst_stale", {31'b0, stale}, 32'h0);
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      sm_shadow[i] = '0;
      sm_valid[i]  = 1'b0;
      mm_shadow[i] = '0;
      mm_valid[i]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    reset_n     = 1'b1;
    last_strobe = cyc;
    repeat (4) tick();
  endtask

  initial begin
    int p0;
    reset_n    = 1'b1;
    tl_cfg_add = 4'h0;
    tl_cfg_ctl = '0;
    rd_addr    = 4'h0;
    #2;
    do_reset();

    // First capture of address 15.
    issue(4'hF, 32'h0000_1A3B, 8);
    check("my_id_first", {16'b0, my_id}, 32'h0000_D1D8);
    check("my_id_valid_first", {31'b0, my_id_valid}, 32'h1);

    // Identical rewrite, then a new value.
    issue(4'hE, 32'h1234_5678, 8);
    issue(4'hF, 32'h0000_1A3B, 8);
    issue(4'hE, 32'h0, 8);
    issue(4'hF, 32'h0000_0008, 8);
    check("my_id_second", {16'b0, my_id}, 32'h0000_0040);

    // Walk all addresses; only 0, 1 and 15 are shadowed.
    p0 = n_pulses;
    for (int unsigned a = 0; a < 16; a++) issue(4'(a), 32'hA5A5_0000 + a, 8);
    check("mask_pulses", n_pulses - p0, 3);
    rd_rand = 1'b0;
    rd_addr = 4'h0; tick();
    rd_addr = 4'h1; tick();
    rd_addr = 4'h5; tick();
    tick();

    // Readback held on 15 across a rewrite of 15.
    rd_addr = 4'hF;
    issue(4'hE, 32'h0, 8);
    issue(4'hF, 32'h0000_0123, 8);
    rd_rand = 1'b1;

    // Bus goes quiet long enough to trip the watchdog, then resumes.
    repeat (80) tick();
    check("stale_idle", {31'b0, stale}, 32'h1);
    check("stale_my_id_valid", {31'b0, my_id_valid}, 32'h1);
    issue(4'h0, 32'hDEAD_0000, 8);
    check("stale_cleared", {31'b0, stale}, 32'h0);

    burst(12);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  a;
      logic [31:0] d;
      a    = 4'($urandom);
      a[0] = ~tl_cfg_add[0];
      if ($urandom_range(0, 1) == 1) a[3:1] = a[0] ? 3'b111 : 3'b000;
      d = ($urandom_range(0, 1) == 1) ? 32'h0000_1A3B : $urandom;
      issue(a, d, $urandom_range(5, 10));
    end

    // Reset lands between a toggle and its strobe; the held odd address must
    // not produce a capture after release.
    if (tl_cfg_add[0]) issue(4'h0, 32'h1, 8);
    issue(4'h1, 32'h5555_0001, 2);
    do_reset();
    repeat (12) tick();
    check("post_reset_valid", {31'b0, my_id_valid}, 32'h0);
    issue(4'h0, 32'h7777_0000, 8);
    issue(4'hF, 32'h0000_0ABC, 8);
    check("post_reset_my_id", {16'b0, my_id}, 32'h0000_55E0);

    repeat (10) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
